fir_output_decimator: RTL
=========================

Name: fir_output_decimator

Overview:
- Sits directly downstream of the fully pipelined FIR filter.
- Consumes the filter's 64-bit full-precision output, which is produced every clock with no valid flag.
- Discards the filter's start-up transient, then decimates by DECIM.
- Rounds, shifts and saturates each kept sample to 16 bits and buffers it in a small FIFO with a valid/ready output interface for the next consumer.

Parameters:
- DATA_IN_WIDTH, 64, width of the FIR output word.
- DATA_OUT_WIDTH, 16, width of the requantized output sample.
- SHIFT, 31, arithmetic right shift applied after rounding (removes Q31 coefficient scaling); legal range 1 to DATA_IN_WIDTH-2.
- DECIM, 4, decimation ratio; must be at least 1.
- WARMUP, 104, number of input cycles discarded after reset release (covers filter fill and pipeline latency).
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_IN_WIDTH  signed FIR output, sampled every cycle.
- m_data  out  DATA_OUT_WIDTH  signed head-of-FIFO sample.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: m_data=0, m_valid=0, fifo_level=0, overflow=0. Reset also empties the FIFO, sets the state machine to WARMUP with warmup count 0, and clears the phase counter.
- Reset asserted mid-operation: all contents are lost immediately; warm-up restarts when reset releases.
- State machine, WARMUP: counts cycles from 0. Every data_in is ignored. On the cycle the count reaches WARMUP-1, the state moves to RUN with phase=0.
- State machine, RUN: phase counts 0..DECIM-1 and wraps to 0. data_in is accepted only when phase==0. DECIM=1 accepts every cycle.
- Requantize stage (1 register):
  - Compute r = data_in + 2^(SHIFT-1) in DATA_IN_WIDTH+1 bits (no internal overflow).
  - Arithmetically shift r right by SHIFT. This rounds half toward +inf.
  - Saturate to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1].
  - The register holds the result plus a push flag.
- FIFO write: push occurs the cycle after acceptance. When the FIFO is initially empty, m_valid rises 2 clocks after the edge that samples the accepted data_in.
- FIFO read: show-ahead; m_data always reflects the head entry. A pop occurs when m_valid and m_ready are both high. m_data is undefined-but-stable when m_valid=0; drive the last head value.
- Push and pop in the same cycle: both take effect, including when the FIFO is full, so no drop occurs. fifo_level is unchanged.
- Push while full without a pop: the sample is dropped and overflow is set the next cycle.
- overflow clear: clear_overflow clears overflow. If clear_overflow and a new drop occur in the same cycle, overflow remains 1.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are decided from fifo_level.

Optional Feature:
- Macro FIR_DECIM_AVG_EN.
- Defined:
  - In RUN, the block accumulates DECIM consecutive inputs in DATA_IN_WIDTH+$clog2(DECIM) bits, starting with phase 0.
  - On phase DECIM-1 it requantizes the sum with shift SHIFT+$clog2(DECIM), using the same round/saturate rules.
  - The push occurs the following cycle. DECIM must be a power of 2.
  - Output rate is unchanged.
- Not defined: pick-one decimation as described in Behaviour; no accumulator logic.

Test Plan:
- Warm-up: reset high 3 cycles, then low; drive data_in=1000·2^31 constantly -> m_valid stays 0 through the edges that sample cycles 0..103; the sample at cycle 104 is accepted; m_valid=1 two edges later with m_data=1000. Default parameters apply.
- Decimation: after warm-up, data_in=k·2^31 on RUN cycle k (k=0,1,2,...) with m_ready=1 -> output sequence 0,4,8,12.
- Rounding: 5·2^31+2^30 -> 6; 5·2^31+2^30-1 -> 5; -5·2^31-2^30 -> -5; -5·2^31-2^30-1 -> -6.
- Saturation: 40000·2^31 -> 32767; -40000·2^31 -> -32768; 2^63-1 -> 32767.
- Backpressure/overflow: m_ready=0 for 40 RUN cycles -> fifo_level reaches 8, the 9th accepted sample is dropped, overflow=1. Pulse clear_overflow -> overflow=0. Raise m_ready -> the 8 stored samples drain in order, one per cycle.
- Full with simultaneous push/pop, then reset mid-stream: with FIFO full, m_ready=1 on a push cycle -> no drop, level stays 8. Assert reset -> m_valid=0 and fifo_level=0 immediately, and WARMUP repeats in full.

Source files
------------

// File: rtl/fir_output_decimator.sv
// FIR output decimator: warm-up discard, decimate, requantize, output FIFO.
// Define FIR_DECIM_AVG_EN to average DECIM inputs instead of picking one.
module fir_output_decimator #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int SHIFT          = 31,
  parameter int DECIM          = 4,
  parameter int WARMUP         = 104,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_IN_WIDTH-1:0]      data_in,
  output logic [DATA_OUT_WIDTH-1:0]     m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int W   = DATA_IN_WIDTH;
  localparam int DOW = DATA_OUT_WIDTH;
  localparam int LD  = (DECIM > 1) ? $clog2(DECIM) : 0;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
`ifdef FIR_DECIM_AVG_EN
  localparam int SW  = W + LD;
  localparam int SH  = SHIFT + LD;
`else
  localparam int SW  = W;
  localparam int SH  = SHIFT;
`endif

  localparam int OMAX_I = (1 << (DOW - 1)) - 1;
  localparam int OMIN_I = -(1 << (DOW - 1));
  localparam logic signed [SW:0] OMAX = (SW+1)'(OMAX_I);
  localparam logic signed [SW:0] OMIN = (SW+1)'(OMIN_I);
  localparam logic signed [SW:0] HALF = (SW+1)'(1) << (SH - 1);

  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]   phase_q, phase_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WARMUP;
      wcnt_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_WARMUP: begin
        wcnt_d = wcnt_q + CW'(1);
        if (wcnt_q == CW'(WARMUP - 1)) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (phase_q == PW'(DECIM - 1))
          phase_d = '0;
        else
          phase_d = phase_q + PW'(1);
      end
      default: state_d = ST_WARMUP;
    endcase
  end

  logic signed [W-1:0]  din;
  logic signed [SW-1:0] src;
  logic                 take;
  logic                 run;

  assign din = $signed(data_in);
  assign run = (state_q == ST_RUN);

`ifdef FIR_DECIM_AVG_EN
  logic signed [SW-1:0] acc_q;
  logic signed [SW-1:0] sum;

  // Phase 0 restarts the sum so no separate clear cycle is needed
  assign sum  = ((phase_q == '0) ? '0 : acc_q) + SW'(din);
  assign src  = sum;
  assign take = run && (phase_q == PW'(DECIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_q <= '0;
    else if (run)
      acc_q <= sum;
  end
`else
  assign src  = din;
  assign take = run && (phase_q == '0);
`endif

  logic signed [SW:0] rnd;
  logic signed [SW:0] shf;
  logic [DOW-1:0]     sat;

  // Extra guard bit keeps the rounding add from wrapping
  always_comb begin
    rnd = $signed({src[SW-1], src}) + HALF;
    shf = rnd >>> SH;
    if (shf > OMAX)
      sat = OMAX[DOW-1:0];
    else if (shf < OMIN)
      sat = OMIN[DOW-1:0];
    else
      sat = shf[DOW-1:0];
  end

  logic           q_push;
  logic [DOW-1:0] q_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_push <= 1'b0;
      q_data <= '0;
    end else begin
      q_push <= take;
      if (take)
        q_data <= sat;
    end
  end

  logic [DOW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic           full, pop, wr, drop, keep;

  assign full   = (fifo_level == LW'(FIFO_DEPTH));
  assign pop    = m_valid && m_ready;
  assign wr     = q_push && (!full || pop);
  assign drop   = q_push && full && !pop;
  assign rd_nxt = rd_ptr + AW'(pop);
  // Entries that survive this edge and were written before it
  assign keep   = (fifo_level != LW'(pop));

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= q_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_nxt;
      fifo_level <= fifo_level + LW'(wr) - LW'(pop);
      m_valid    <= keep;
      if (keep)
        m_data <= mem[rd_nxt];
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

endmodule
